lbm_frame_reader: RTL and testbench

Host-side initiator for the solver's GPIO pixel-readout port. It sweeps the pixel index across the lattice and drives `{host_transmission, index}` onto the GPIO request word. After a fixed settle time it captures the returned `u_x`/`u_y`/`rho` words and emits one record per pixel on a valid/ready stream. It sits on the host/PS side of the GPIO link, opposite the solver's host interface, and feeds a DMA or UART packer.

---
 rtl/lbm_frame_reader_pkg.sv | 22 ++
 rtl/lbm_frame_reader.sv | 150 +++++++++++++++
 tb/tb_lbm_frame_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbm_frame_reader_pkg.sv
// Shared GPIO link definitions for the host-side frame reader.
// Both ends of the GPIO link take the request-word layout from here.
package lbm_frame_reader_pkg;

  localparam int HOST_TX_BIT = 15;
  localparam int GPIO_IDX_W  = 15;
  localparam int SAMPLE_W    = 16;
  localparam int GPIO_W      = GPIO_IDX_W + 1;
  localparam int RECORD_W    = 3 * SAMPLE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Build a request word from the transmission flag and a pixel index.
  function automatic logic [GPIO_W-1:0] gpio_word(input logic tx,
                                                  input logic [GPIO_IDX_W-1:0] idx);
    return {tx, idx};
  endfunction

endpackage

// File: rtl/lbm_frame_reader.sv
// Host-side GPIO pixel readout initiator: sweeps the pixel index, waits a
// settle time, captures {rho, uy, ux} and emits one record per pixel.
module lbm_frame_reader
  import lbm_frame_reader_pkg::*;
#(
  parameter int NUM_PIXELS = 2500,
  parameter int IDX_W      = 15,
  parameter int SETTLE     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                sim_idle,
  input  logic [SAMPLE_W-1:0] gpio_ux,
  input  logic [SAMPLE_W-1:0] gpio_uy,
  input  logic [SAMPLE_W-1:0] gpio_rho,
  output logic [GPIO_W-1:0]   gpio_o,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RECORD_W-1:0] m_data,
  output logic [IDX_W-1:0]    m_idx,
  output logic                m_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_count
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GPIO_W-1:0]   gpio_q, gpio_d;
  logic                m_valid_q, m_valid_d;
  logic [RECORD_W-1:0] m_data_q, m_data_d;
  logic [IDX_W-1:0]    m_idx_q, m_idx_d;
  logic                m_last_q, m_last_d;
  logic                done_q, done_d;
  logic [15:0]         frame_count_q, frame_count_d;

  // Next-state logic: abort overrides everything outside IDLE.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    gpio_d        = gpio_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_idx_d       = m_idx_q;
    m_last_d      = m_last_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;

    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      gpio_d    = '0;
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_REQ;
            idx_d   = '0;
            cnt_d   = '0;
            gpio_d  = gpio_word(1'b1, '0);
          end
        end
        ST_REQ: begin
          // A low transmission bit marks a sim_idle gap; the settle count
          // only advances once the request has been re-presented.
          if (!sim_idle) begin
            gpio_d = gpio_word(1'b0, GPIO_IDX_W'(idx_q));
            cnt_d  = '0;
          end else if (!gpio_q[HOST_TX_BIT]) begin
            gpio_d = gpio_word(1'b1, GPIO_IDX_W'(idx_q));
            cnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            m_data_d  = {gpio_rho, gpio_uy, gpio_ux};
            m_idx_d   = idx_q;
            m_last_d  = (idx_q == IDX_LAST);
            m_valid_d = 1'b1;
            state_d   = ST_EMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_EMIT: begin
          if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
              gpio_d  = '0;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              gpio_d  = gpio_word(1'b1, GPIO_IDX_W'(idx_q + 1'b1));
              state_d = ST_REQ;
            end
          end
        end
        ST_DONE: begin
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      gpio_q        <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_idx_q       <= '0;
      m_last_q      <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      gpio_q        <= gpio_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_idx_q       <= m_idx_d;
      m_last_q      <= m_last_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign gpio_o      = gpio_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_idx       = m_idx_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lbm_frame_reader.sv
// Scoreboard bench for lbm_frame_reader: stimulus pushes expected records,
// a negedge monitor pops and compares on every handshake.
module tb_lbm_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, sim_idle, m_ready;
  logic [15:0] gpio_ux, gpio_uy, gpio_rho, gpio_o, frame_count;
  logic        m_valid, m_last, busy, done;
  logic [47:0] m_data;
  logic [14:0] m_idx;

  lbm_frame_reader #(.NUM_PIXELS(4), .IDX_W(15), .SETTLE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sim_idle(sim_idle),
    .gpio_ux(gpio_ux), .gpio_uy(gpio_uy), .gpio_rho(gpio_rho), .gpio_o(gpio_o),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .done(done), .frame_count(frame_count)
  );

  // Single-pixel instance for the NUM_PIXELS=1 / SETTLE=1 boundary.
  logic        start1, abort1, idle1, ready1, m_valid1, m_last1, busy1, done1;
  logic [15:0] gpio_o1, fc1;
  logic [15:0] ux1, uy1, rho1;
  logic [47:0] m_data1;
  logic [14:0] m_idx1;
  assign abort1 = 1'b0;
  assign idle1  = 1'b1;
  assign ready1 = 1'b1;
  assign ux1    = 16'h0001;
  assign uy1    = 16'h0002;
  assign rho1   = 16'h0003;

  lbm_frame_reader #(.NUM_PIXELS(1), .IDX_W(15), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .sim_idle(idle1),
    .gpio_ux(ux1), .gpio_uy(uy1), .gpio_rho(rho1), .gpio_o(gpio_o1),
    .m_valid(m_valid1), .m_ready(ready1), .m_data(m_data1), .m_idx(m_idx1),
    .m_last(m_last1), .busy(busy1), .done(done1), .frame_count(fc1)
  );

  // Responder: answers with a request word seen two edges ago, so a
  // capture before the third edge returns stale or 0xDEAD words.
  logic [15:0] g1, g2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1 <= '0;
      g2 <= '0;
    end else begin
      g1 <= gpio_o;
      g2 <= g1;
    end
  end

  function automatic logic [47:0] respond(input logic [15:0] g);
    logic [15:0] i;
    if (!g[15]) return {3{16'hDEAD}};
    i = {1'b0, g[14:0]};
    return {16'h1000 + i, 16'h0000 - i, i};
  endfunction

  assign {gpio_rho, gpio_uy, gpio_ux} = respond(g2);

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_rec;

  // Hand-computed records {rho, uy, ux} for pixels 0..3.
  logic [47:0] exp_data [4] = '{48'h1000_0000_0000, 48'h1001_FFFF_0001,
                                48'h1002_FFFE_0002, 48'h1003_FFFD_0003};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_records(input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({(i == 3), 15'(i), exp_data[i]});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gpio(input logic [15:0] val, input int maxc);
    int n = 0;
    while (gpio_o !== val && n < maxc) begin
      tick(1);
      n++;
    end
    if (gpio_o !== val) check("wait gpio timeout", gpio_o, val);
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (m_valid !== 1'b1 && n < maxc) begin
      tick(1);
      n++;
    end
    if (m_valid !== 1'b1) check("wait valid timeout", m_valid, 1);
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (done !== 1'b1 && n < maxc);
    if (done !== 1'b1) check("wait done timeout", done, 1);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected record: got idx %0d expected none", m_idx);
      end else begin
        exp_rec = sb.pop_front();
        check("record {last,idx,data}", {m_last, m_idx, m_data}, exp_rec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; sim_idle = 1'b1; m_ready = 1'b1;
    start1 = 1'b0;
    #12;
    check("reset outputs", {gpio_o, m_valid, m_data, m_idx, m_last, busy, done, frame_count},
          '0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // Basic frame
    push_records(4);
    start_frame();
    check("start gpio", gpio_o, 16'h8000);
    check("start busy", busy, 1);
    wait_done(60, n);
    check("frame cycles", n + 1, 18);
    check("frame_count 1", frame_count, 1);
    check("busy at done", busy, 0);
    tick(1);
    check("done one cycle", done, 0);

    // Backpressure on pixel 2
    push_records(4);
    start_frame();
    wait_gpio(16'h8002, 40);
    m_ready = 1'b0;
    wait_valid(10);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("bp valid", m_valid, 1);
      check("bp data", m_data, 48'h1002_FFFE_0002);
      check("bp idx", m_idx, 2);
      check("bp gpio", gpio_o, 16'h8002);
    end
    m_ready = 1'b1;
    wait_done(60, n);
    check("frame_count 2", frame_count, 2);

    // sim_idle gap at settle count 1 of pixel 1
    push_records(4);
    start_frame();
    wait_gpio(16'h8001, 40);
    tick(1);
    sim_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("gap gpio", gpio_o, 16'h0001);
      check("gap valid", m_valid, 0);
    end
    sim_idle = 1'b1;
    tick(1);
    check("resume gpio", gpio_o, 16'h8001);
    tick(2);
    check("settle restart no early valid", m_valid, 0);
    tick(1);
    check("settle restart valid", m_valid, 1);
    check("settle restart idx", m_idx, 1);
    wait_done(60, n);
    check("frame_count 3", frame_count, 3);

    // Abort while emitting pixel 3
    push_records(3);
    start_frame();
    wait_gpio(16'h8003, 40);
    m_ready = 1'b0;
    wait_valid(10);
    check("abort idx", m_idx, 3);
    check("abort last", m_last, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort valid", m_valid, 0);
    check("abort gpio", gpio_o, 16'h0000);
    check("abort busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      check("abort no done", done, 0);
      tick(1);
    end
    check("abort frame_count", frame_count, 3);
    m_ready = 1'b1;
    push_records(4);
    start_frame();
    check("restart gpio", gpio_o, 16'h8000);
    wait_done(60, n);
    check("frame_count 4", frame_count, 4);

    // Reset mid-frame
    tick(1);
    start_frame();
    tick(1);
    #3;
    rst = 1'b0;
    #1;
    check("async reset outputs",
          {gpio_o, m_valid, m_data, m_idx, m_last, busy, done, frame_count}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    check("idle after reset busy", busy, 0);
    check("idle after reset gpio", gpio_o, 16'h0000);

    // frame_count wrap, start ignored while busy
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    tick(1);
    release dut.frame_count_q;
    check("preload frame_count", frame_count, 16'hFFFF);
    push_records(4);
    start_frame();
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(60, n);
    check("busy-start frame cycles", n + 5, 18);
    check("frame_count wrap", frame_count, 16'h0000);
    tick(2);
    check("start not remembered", busy, 0);

    // Single-pixel frame, SETTLE=1
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    check("np1 gpio", gpio_o1, 16'h8000);
    tick(1);
    check("np1 record", {m_valid1, m_last1, m_idx1, m_data1},
          {1'b1, 1'b1, 15'd0, 48'h0003_0002_0001});
    tick(1);
    check("np1 valid drop", m_valid1, 0);
    tick(1);
    check("np1 done", {done1, fc1}, {1'b1, 16'd1});

    check("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
